// File: rtl/uart_transmitter_if.sv
// Byte-in / serial-out port bundle for the 8N1 UART transmitter.
// The producer uses the master modport and the transmitter uses the slave modport.
interface uart_transmitter_if;
   logic [7:0] i_data;
   logic       i_valid;
   logic       o_ready;
   logic       o_tx;
   logic       o_busy;
   logic       o_done;

   modport master (
      output i_data,
      output i_valid,
      input  o_ready,
      input  o_tx,
      input  o_busy,
      input  o_done
   );

   modport slave (
      input  i_data,
      input  i_valid,
      output o_ready,
      output o_tx,
      output o_busy,
      output o_done
   );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts one byte per valid/ready handshake and
// shifts it out LSB first, holding each bit for FULL_BIT clock cycles.
//
//   state     | meaning
//   IDLE      | line held at 1, ready for a byte
//   START_BIT | line driven 0 for one bit period
//   DATA_BITS | data bits 0..7 shifted out, LSB first
//   STOP_BIT  | line driven 1 for one bit period, then o_done pulses
module uart_transmitter #(
   parameter int unsigned FULL_BIT = 22274
) (
   input  logic               clk,
   input  logic               i_reset_n,
   uart_transmitter_if.slave  tx_if
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START_BIT = 2'd1,
      DATA_BITS = 2'd2,
      STOP_BIT  = 2'd3
   } state_t;

   localparam logic [15:0] CNT_LAST = 16'(FULL_BIT - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        done_q, done_d;
   logic        armed_q;

   logic bit_end;
   logic ready;
   logic accept;

   // armed_q keeps o_ready low until the first edge after reset release.
   assign ready   = (state_q == IDLE) && armed_q;
   assign accept  = tx_if.i_valid && ready;
   assign bit_end = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         armed_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            tx_d  = 1'b1;
            if (accept) begin
               shift_d = tx_if.i_data;
               tx_d    = 1'b0;
               state_d = START_BIT;
            end
         end

         START_BIT: begin
            if (bit_end) begin
               cnt_d   = '0;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               state_d = DATA_BITS;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         DATA_BITS: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
                  idx_d   = '0;
                  tx_d    = 1'b1;
                  state_d = STOP_BIT;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         STOP_BIT: begin
            if (bit_end) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign tx_if.o_ready = ready;
   assign tx_if.o_tx    = tx_q;
   assign tx_if.o_busy  = (state_q != IDLE);
   assign tx_if.o_done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: three instances (FULL_BIT 4, 2, 2000)
// share clock and reset; sel routes stimulus to one instance at a time.
module tb_uart_transmitter;

   logic       clk;
   logic       rst_n;
   logic [1:0] sel;
   logic       valid_tb;
   logic [7:0] data_tb;
   int         n_checks;
   int         n_fail;

   uart_transmitter_if if0();
   uart_transmitter_if if1();
   uart_transmitter_if if2();

   uart_transmitter #(.FULL_BIT(4))    u_dut0 (.clk(clk), .i_reset_n(rst_n), .tx_if(if0.slave));
   uart_transmitter #(.FULL_BIT(2))    u_dut1 (.clk(clk), .i_reset_n(rst_n), .tx_if(if1.slave));
   uart_transmitter #(.FULL_BIT(2000)) u_dut2 (.clk(clk), .i_reset_n(rst_n), .tx_if(if2.slave));

   assign if0.i_valid = valid_tb && (sel == 2'd0);
   assign if1.i_valid = valid_tb && (sel == 2'd1);
   assign if2.i_valid = valid_tb && (sel == 2'd2);
   assign if0.i_data  = data_tb;
   assign if1.i_data  = data_tb;
   assign if2.i_data  = data_tb;

   logic tx_m, busy_m, done_m, ready_m;
   int   fb_m;
   assign tx_m    = (sel == 2'd0) ? if0.o_tx    : (sel == 2'd1) ? if1.o_tx    : if2.o_tx;
   assign busy_m  = (sel == 2'd0) ? if0.o_busy  : (sel == 2'd1) ? if1.o_busy  : if2.o_busy;
   assign done_m  = (sel == 2'd0) ? if0.o_done  : (sel == 2'd1) ? if1.o_done  : if2.o_done;
   assign ready_m = (sel == 2'd0) ? if0.o_ready : (sel == 2'd1) ? if1.o_ready : if2.o_ready;
   assign fb_m    = (sel == 2'd0) ? 4 : (sel == 2'd1) ? 2 : 2000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Called at a negedge where the frame's first (start) cycle is visible.
   // poke >= 0: pulse valid with 0x3C at that frame cycle; scramble: new random data every cycle.
   task automatic capture(input string tag, input logic [7:0] b, input int poke, input bit scramble);
      logic [9:0] frame;
      int         len;
      int         errs;
      int         dones;
      int         fb;
      fb    = fb_m;
      frame = {1'b1, b, 1'b0};
      len   = 0;
      errs  = 0;
      dones = 0;
      while (busy_m && len < 10 * fb + 2) begin
         if (len >= 10 * fb || tx_m !== frame[len / fb]) errs++;
         if (done_m) dones++;
         if (poke >= 0) begin
            if (len == poke) begin
               valid_tb = 1'b1;
               data_tb  = 8'h3C;
            end else begin
               valid_tb = 1'b0;
            end
         end
         if (scramble) data_tb = 8'($urandom);
         @(negedge clk);
         len++;
      end
      check_val({tag, "_len"}, len, 10 * fb);
      check_val({tag, "_bits"}, errs, 0);
      check_val({tag, "_done_early"}, dones, 0);
      check_val({tag, "_done"}, done_m, 1'b1);
      check_val({tag, "_idle_tx"}, tx_m, 1'b1);
   endtask

   task automatic send(input string tag, input logic [7:0] b, input int poke, input bit scramble);
      @(negedge clk);
      valid_tb = 1'b1;
      data_tb  = b;
      @(negedge clk);
      check_val({tag, "_lat"}, busy_m, 1'b1);
      valid_tb = 1'b0;
      capture(tag, b, poke, scramble);
      @(negedge clk);
      check_val({tag, "_done_clr"}, done_m, 1'b0);
   endtask

   initial begin
      int busy_cnt;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      sel      = 2'd0;
      valid_tb = 1'b0;
      data_tb  = 8'h00;

      repeat (3) @(negedge clk);
      check_val("rst_tx", tx_m, 1'b1);
      check_val("rst_busy", busy_m, 1'b0);
      check_val("rst_done", done_m, 1'b0);
      check_val("rst_ready", ready_m, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("ready_after_rst", ready_m, 1'b1);

      send("a5", 8'hA5, -1, 1'b0);

      // back-to-back 0x00 then 0xFF with valid held
      @(negedge clk);
      valid_tb = 1'b1;
      data_tb  = 8'h00;
      @(negedge clk);
      check_val("b2b_lat", busy_m, 1'b1);
      data_tb = 8'hFF;
      capture("b2b0", 8'h00, -1, 1'b0);
      @(negedge clk);
      check_val("b2b_gap", busy_m, 1'b1);
      valid_tb = 1'b0;
      capture("b2b1", 8'hFF, -1, 1'b0);
      @(negedge clk);
      check_val("b2b_done_clr", done_m, 1'b0);

      // valid while busy is ignored
      send("ign", 8'h55, 13, 1'b0);
      busy_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy_m) busy_cnt++;
      end
      check_val("ign_no_frame", busy_cnt, 0);

      send("scr", 8'h0F, -1, 1'b1);
      data_tb = 8'h00;

      // reset mid-frame, then a clean frame
      @(negedge clk);
      valid_tb = 1'b1;
      data_tb  = 8'hA5;
      @(negedge clk);
      valid_tb = 1'b0;
      repeat (17) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("abort_tx", tx_m, 1'b1);
      check_val("abort_busy", busy_m, 1'b0);
      check_val("abort_done", done_m, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check_val("abort_no_done", done_m, 1'b0);
      valid_tb = 1'b1;
      data_tb  = 8'h81;
      rst_n    = 1'b1;
      #1;
      check_val("rel_ready", ready_m, 1'b0);
      @(negedge clk);
      check_val("rel_no_xfer", busy_m, 1'b0);
      check_val("rel_ready1", ready_m, 1'b1);
      @(negedge clk);
      check_val("x81_lat", busy_m, 1'b1);
      valid_tb = 1'b0;
      capture("x81", 8'h81, -1, 1'b0);
      @(negedge clk);

      sel = 2'd1;
      send("fb2", 8'h6E, -1, 1'b0);
      sel = 2'd2;
      send("fb2000", 8'h6E, -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
